// File: rtl/pipe_pkg.sv
// Shared types and defaults for the handshaked pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit, control and data. Kill drops the entry
// and parks control at CTRL_RST but leaves the data bits untouched.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W   = 3,
    parameter int                 DATA_W   = 101,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ctrl_in;
            data  <= data_in;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush and a
// saturating stall counter. in_ready is a flop, so out_ready never reaches it.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 101,
    parameter int                 CTRL_W   = 3,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
    parameter int                 CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t state, state_next;

    logic              accept, drain;
    logic              main_load, main_kill, main_from_skid;
    logic              skid_load, skid_kill;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] skid_data, main_data_in;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != SKID);
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_next = FULL;
                FULL: begin
                    if (accept && !drain)      state_next = SKID;
                    else if (!accept && drain) state_next = EMPTY;
                end
                SKID:    if (drain) state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Main is killed when it drains with nothing behind it, so a bubble
    // always carries CTRL_RST.
    always_comb begin
        main_load      = 1'b0;
        main_kill      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_kill      = 1'b0;
        if (flush) begin
            main_kill = 1'b1;
            skid_kill = 1'b1;
        end else begin
            case (state)
                EMPTY: main_load = accept;
                FULL: begin
                    if (accept && drain) main_load = 1'b1;
                    else if (accept)     skid_load = 1'b1;
                    else if (drain)      main_kill = 1'b1;
                end
                SKID: begin
                    if (drain) begin
                        main_load      = skid_valid;
                        main_from_skid = 1'b1;
                        skid_kill      = 1'b1;
                    end
                end
                default: begin
                    main_kill = 1'b1;
                    skid_kill = 1'b1;
                end
            endcase
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .kill    (main_kill),
        .ctrl_in (main_ctrl_in),
        .data_in (main_data_in),
        .valid   (out_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .kill    (skid_kill),
        .ctrl_in (in_ctrl),
        .data_in (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench: two instances share stimulus, one with a 4-bit stall
// counter so saturation shows up alongside the 16-bit one.
module tb_pipe_stage_hs;

    localparam int          DW  = 101;
    localparam int          CW  = 3;
    localparam logic [2:0]  CRST = 3'b010;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   cnt16;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(cnt16)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .stall_cnt(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b1, 3'b111, DW'(55));
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== CRST) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", out_ctrl, CRST); end
        total++; if (out_data !== DW'(0)) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (cnt16 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt16); end
        rst = 1'b0;
        offer(1'b0, 3'b000, DW'(0));
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
            offer(1'b1, 3'b101, DW'(i));
            tick();
            total++; if (out_valid !== 1'b1 || out_ctrl !== 3'b101 || out_data !== DW'(i))
                begin bad++; $display("FAIL stream_out i=%0d got=%b/%b/%0d exp=1/101/%0d", i, out_valid, out_ctrl, out_data, i); end
        end
        offer(1'b0, 3'b000, DW'(0));
        tick();
        total++; if (out_valid !== 1'b0 || out_ctrl !== CRST)
            begin bad++; $display("FAIL stream_bubble got=%b/%b exp=0/%b", out_valid, out_ctrl, CRST); end
        total++; if (cnt16 !== 16'd0) begin bad++; $display("FAIL stream_cnt got=%0d exp=0", cnt16); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b1;
        offer(1'b1, 3'b001, DW'('hA));
        tick();
        out_ready = 1'b0;
        offer(1'b1, 3'b011, DW'('hB));
        tick();
        total++; if (out_data !== DW'('hA) || out_ctrl !== 3'b001 || in_ready !== 1'b0)
            begin bad++; $display("FAIL bp_hold_a got=%0h/%b/rdy%b exp=a/001/rdy0", out_data, out_ctrl, in_ready); end
        offer(1'b1, 3'b110, DW'('hC));
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_data !== DW'('hA) || in_ready !== 1'b0)
            begin bad++; $display("FAIL bp_stable_a got=%b/%0h/rdy%b exp=1/a/rdy0", out_valid, out_data, in_ready); end
        total++; if (cnt16 !== 16'd3) begin bad++; $display("FAIL bp_cnt_stall got=%0d exp=3", cnt16); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== DW'('hB) || out_ctrl !== 3'b011 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_out_b got=%0h/%b/rdy%b exp=b/011/rdy1", out_data, out_ctrl, in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== DW'('hC) || out_ctrl !== 3'b110)
            begin bad++; $display("FAIL bp_out_c got=%b/%0h/%b exp=1/c/110", out_valid, out_data, out_ctrl); end
        offer(1'b0, 3'b000, DW'(0));
        tick();
        total++; if (out_valid !== 1'b0 || out_ctrl !== CRST)
            begin bad++; $display("FAIL bp_empty got=%b/%b exp=0/%b", out_valid, out_ctrl, CRST); end
        total++; if (cnt16 !== 16'd3) begin bad++; $display("FAIL bp_cnt_final got=%0d exp=3", cnt16); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(1'b1, 3'b011, DW'('h11));
        tick();
        offer(1'b1, 3'b100, DW'('h22));
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_skid got=%b exp=0", in_ready); end
        flush = 1'b1;
        offer(1'b1, 3'b111, DW'('h33));
        tick();
        flush = 1'b0;
        offer(1'b0, 3'b000, DW'(0));
        total++; if (out_valid !== 1'b0 || out_ctrl !== CRST || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_skid got=%b/%b/rdy%b exp=0/%b/rdy1", out_valid, out_ctrl, in_ready, CRST); end
        total++; if (out_data !== DW'('h11)) begin bad++; $display("FAIL flush_data_kept got=%0h exp=11", out_data); end
        total++; if (cnt16 !== 16'd4) begin bad++; $display("FAIL flush_cnt got=%0d exp=4", cnt16); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_stale got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        offer(1'b1, 3'b110, DW'('h44));
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== DW'('h44) || out_ctrl !== 3'b110)
            begin bad++; $display("FAIL flush_next got=%b/%0h/%b exp=1/44/110", out_valid, out_data, out_ctrl); end
        // Flush in FULL while an input is being accepted: that input is lost.
        offer(1'b1, 3'b001, DW'('h55));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, 3'b000, DW'(0));
        total++; if (out_valid !== 1'b0 || out_ctrl !== CRST)
            begin bad++; $display("FAIL flush_full got=%b/%b exp=0/%b", out_valid, out_ctrl, CRST); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        offer(1'b1, 3'b101, DW'('h66));
        tick();
        offer(1'b0, 3'b000, DW'(0));
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (out_data !== DW'('h66) || out_ctrl !== 3'b101)
                begin bad++; $display("FAIL sat_stable i=%0d got=%0h/%b exp=66/101", i, out_data, out_ctrl); end
        end
        total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt4); end
        total++; if (cnt16 !== 16'd24) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=24", cnt16); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 3'b001, DW'('h77));
        tick();
        offer(1'b1, 3'b011, DW'('h88));
        tick();
        offer(1'b0, 3'b000, DW'(0));
        for (int i = 0; i < 6; i++) tick();
        total++; if (cnt16 !== 16'd7 || in_ready !== 1'b0)
            begin bad++; $display("FAIL mid_setup got=cnt%0d/rdy%b exp=cnt7/rdy0", cnt16, in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || out_ctrl !== CRST || out_data !== DW'(0) || in_ready !== 1'b1 || cnt16 !== 16'd0)
            begin bad++; $display("FAIL mid_reset got=%b/%b/%0h/rdy%b/cnt%0d exp=0/%b/0/rdy1/cnt0",
                                  out_valid, out_ctrl, out_data, in_ready, cnt16, CRST); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== DW'(0))
            begin bad++; $display("FAIL mid_no_stale1 got=%b/%0h exp=0/0", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== DW'(0))
            begin bad++; $display("FAIL mid_no_stale2 got=%b/%0h exp=0/0", out_valid, out_data); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
